mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 33 +++
 rtl/mul_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// Bundle of requester handshakes, response bus and shared Booth multiplier control.
// slave = arbiter side, master = requesters plus multiplier side.
interface mul_arbiter_if;
  logic         req0;
  logic         req1;
  logic [63:0]  a0;
  logic [63:0]  b0;
  logic [63:0]  a1;
  logic [63:0]  b1;
  logic         done0;
  logic         done1;
  logic [127:0] result;
  logic         err;
  logic         busy;
  logic         mul_start;
  logic         mul_clear;
  logic [63:0]  mul_multiplicand;
  logic [63:0]  mul_multiplier;
  logic [127:0] mul_result;
  logic [1:0]   mul_state;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_result, mul_state,
    output done0, done1, result, err, busy,
           mul_start, mul_clear, mul_multiplicand, mul_multiplier
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_result, mul_state,
    input  done0, done1, result, err, busy,
           mul_start, mul_clear, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one signed 64x64 Booth multiplier between two requesters,
// with a WAIT timeout that aborts a stuck multiplier and reports err with a zero result.
module mul_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd80
) (
  input  logic          clk,
  input  logic          reset,
  mul_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_DONE = 2'b01;

  state_t        r_state;
  state_t        w_next;
  logic          r_ptr;
  logic          r_gid;
  logic [63:0]   r_opa;
  logic [63:0]   r_opb;
  logic [7:0]    r_cnt;
  logic [127:0]  r_result;
  logic          r_err;

  logic          w_grant;
  logic          w_win;
  logic          w_mul_done;
  logic          w_timeout;
  logic          w_mul_idle;

  always_comb begin
    w_mul_idle = (bus.mul_state == MS_IDLE);
    w_mul_done = (bus.mul_state == MS_DONE);
    w_timeout  = (r_cnt == TIMEOUT);
    // r_ptr names the requester that wins a tie; a lone request always wins
    w_win      = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
    w_grant    = (r_state == S_IDLE) && w_mul_idle && (bus.req0 || bus.req1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_mul_done || w_timeout) w_next = S_CLEAR;
      S_CLEAR: if (w_mul_idle) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= 1'b0;
      r_gid    <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_opa <= w_win ? bus.a1 : bus.a0;
        r_opb <= w_win ? bus.b1 : bus.b0;
        r_gid <= w_win;
      end
      case (r_state)
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // a DONE arriving on the timeout cycle still delivers the real product
          if (w_mul_done) begin
            r_result <= bus.mul_result;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        S_RESP:  r_ptr <= ~r_gid;
        default: ;
      endcase
    end
  end

  // mul_clear is gated by reset so every output reads 0 while reset is held
  assign bus.mul_start        = (r_state == S_ISSUE);
  assign bus.mul_clear        = !reset && ((r_state == S_CLEAR) ||
                                           ((r_state == S_IDLE) && !w_mul_idle));
  assign bus.done0            = (r_state == S_RESP) && !r_gid;
  assign bus.done1            = (r_state == S_RESP) &&  r_gid;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.result           = r_result;
  assign bus.err              = r_err;
  assign bus.mul_multiplicand = r_opa;
  assign bus.mul_multiplier   = r_opb;

  a_done_onehot: assert property (@(posedge clk) disable iff (reset)
    !(bus.done0 && bus.done1));
  a_start_clear_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.mul_start && bus.mul_clear));

endmodule
